// File: rtl/instruction_decoder.sv
// instruction_decoder
// Decode stage of the CME341 microprocessor. It registers each program-memory
// word into the instruction register and decodes it into register-load
// enables, data-bus source selects, ALU controls and jump controls for the
// program sequencer. It also holds the zero flag and counts retired
// instructions. After a taken jump the single fall-through fetch is squashed.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   pm_data      instruction word from program memory
//   alu_zero     ALU result == 0 for the instruction currently in ir
//   ir           instruction register
//   ir_valid     ir holds a live instruction (0 = bubble)
//   reg_en       one-hot load enable: x0 x1 y0 y1 o_reg m i (bit 7 unused)
//   src_sel      data-bus source for moves (7 = ALU result r)
//   use_imm      data bus takes imm instead of src_sel
//   imm          immediate nibble, ir[3:0]
//   alu_en       ALU executes alu_func this cycle
//   alu_func     ir[2:0]
//   jmp, jmp_nz  jump controls to the sequencer
//   jmp_addr     jump target, ir[3:0]
//   dont_jmp     current zero flag, used by the sequencer for jmp_nz
//   instr_count  retired-instruction counter (wraps)

module instruction_decoder #(
  parameter logic [7:0] NOP_WORD = 8'hDF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  pm_data,
  input  logic        alu_zero,
  output logic [7:0]  ir,
  output logic        ir_valid,
  output logic [7:0]  reg_en,
  output logic [2:0]  src_sel,
  output logic        use_imm,
  output logic [3:0]  imm,
  output logic        alu_en,
  output logic [2:0]  alu_func,
  output logic        jmp,
  output logic        jmp_nz,
  output logic [3:0]  jmp_addr,
  output logic        dont_jmp,
  output logic [15:0] instr_count
);

  logic       z_flag;
  logic       is_load;
  logic       is_move;
  logic       is_alu;
  logic       is_jmp;
  logic       is_jnz;
  logic [2:0] dst;
  logic       dst_ok;
  logic       taken_jump;

  // Opcode classification. Everything not matched here (1100_1xxx and
  // 1101_xxxx) falls through as a NOP with no enables.
  always_comb begin
    is_load = (ir[7] == 1'b0);
    is_move = (ir[7:6] == 2'b10);
    is_alu  = (ir[7:3] == 5'b11000);
    is_jmp  = (ir[7:4] == 4'hE);
    is_jnz  = (ir[7:4] == 4'hF);
  end

  // Destination field sits at [6:4] for loads and [5:3] for moves.
  // Destination 7 has no register behind it, and a move onto itself does
  // nothing, so neither produces an enable.
  always_comb begin
    dst    = is_load ? ir[6:4] : ir[5:3];
    dst_ok = (dst != 3'd7) &&
             (is_load || (is_move && (ir[5:3] != ir[2:0])));
  end

  always_comb begin
    reg_en   = 8'h00;
    use_imm  = 1'b0;
    alu_en   = 1'b0;
    alu_func = 3'd0;
    jmp      = 1'b0;
    jmp_nz   = 1'b0;
    if (ir_valid) begin
      if (dst_ok) begin
        reg_en = 8'h01 << dst;
      end
      use_imm  = is_load;
      alu_en   = is_alu;
      alu_func = ir[2:0];
      jmp      = is_jmp;
      jmp_nz   = is_jnz;
    end
  end

  // Field pass-throughs follow ir even during a bubble.
  assign imm      = ir[3:0];
  assign jmp_addr = ir[3:0];
  assign src_sel  = ir[2:0];
  assign dont_jmp = z_flag;

  // jmp/jmp_nz already include ir_valid, so a squashed word can never
  // start a second jump.
  assign taken_jump = jmp | (jmp_nz & ~z_flag);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir          <= NOP_WORD;
      ir_valid    <= 1'b0;
      z_flag      <= 1'b0;
      instr_count <= 16'h0000;
    end else begin
      ir       <= pm_data;
      ir_valid <= ~taken_jump;
      if (alu_en) begin
        z_flag <= alu_zero;
      end
      if (ir_valid) begin
        instr_count <= instr_count + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decoder.sv
module tb_instruction_decoder;

  logic        clk;
  logic        reset_n;
  logic [7:0]  pm_data;
  logic        alu_zero;
  logic [7:0]  ir;
  logic        ir_valid;
  logic [7:0]  reg_en;
  logic [2:0]  src_sel;
  logic        use_imm;
  logic [3:0]  imm;
  logic        alu_en;
  logic [2:0]  alu_func;
  logic        jmp;
  logic        jmp_nz;
  logic [3:0]  jmp_addr;
  logic        dont_jmp;
  logic [15:0] instr_count;

  int checks;
  int failures;

  instruction_decoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pm_data     (pm_data),
    .alu_zero    (alu_zero),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .reg_en      (reg_en),
    .src_sel     (src_sel),
    .use_imm     (use_imm),
    .imm         (imm),
    .alu_en      (alu_en),
    .alu_func    (alu_func),
    .jmp         (jmp),
    .jmp_nz      (jmp_nz),
    .jmp_addr    (jmp_addr),
    .dont_jmp    (dont_jmp),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  word;
    logic        az;       // alu_zero driven while this word is in ir
    logic        valid;
    logic [7:0]  reg_en;
    logic [2:0]  src_sel;
    logic        use_imm;
    logic [3:0]  imm;
    logic        alu_en;
    logic [2:0]  alu_func;
    logic        jmp;
    logic        jmp_nz;
    logic        dont_jmp;
    logic [15:0] count;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] w, input logic az, input logic v,
                              input logic [7:0] re, input logic [2:0] ss, input logic ui,
                              input logic [3:0] im, input logic ae, input logic [2:0] af,
                              input logic j, input logic jn, input logic dj,
                              input logic [15:0] c);
    vec_t r;
    r.word = w; r.az = az; r.valid = v; r.reg_en = re; r.src_sel = ss;
    r.use_imm = ui; r.imm = im; r.alu_en = ae; r.alu_func = af;
    r.jmp = j; r.jmp_nz = jn; r.dont_jmp = dj; r.count = c;
    return r;
  endfunction

  task automatic compare(input vec_t e, input int idx);
    string t;
    t = $sformatf("v%0d_%h", idx, e.word);
    check({t, "_ir"},       16'(ir),          16'(e.word));
    check({t, "_valid"},    16'(ir_valid),    16'(e.valid));
    check({t, "_reg_en"},   16'(reg_en),      16'(e.reg_en));
    check({t, "_src_sel"},  16'(src_sel),     16'(e.src_sel));
    check({t, "_use_imm"},  16'(use_imm),     16'(e.use_imm));
    check({t, "_imm"},      16'(imm),         16'(e.imm));
    check({t, "_jmp_addr"}, 16'(jmp_addr),    16'(e.imm));
    check({t, "_alu_en"},   16'(alu_en),      16'(e.alu_en));
    check({t, "_alu_func"}, 16'(alu_func),    16'(e.alu_func));
    check({t, "_jmp"},      16'(jmp),         16'(e.jmp));
    check({t, "_jmp_nz"},   16'(jmp_nz),      16'(e.jmp_nz));
    check({t, "_dont_jmp"}, 16'(dont_jmp),    16'(e.dont_jmp));
    check({t, "_count"},    instr_count,      e.count);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ir"},       16'(ir),       16'h00DF);
    check({tag, "_valid"},    16'(ir_valid), 16'h0);
    check({tag, "_reg_en"},   16'(reg_en),   16'h0);
    check({tag, "_src_sel"},  16'(src_sel),  16'h7);
    check({tag, "_use_imm"},  16'(use_imm),  16'h0);
    check({tag, "_imm"},      16'(imm),      16'hF);
    check({tag, "_jmp_addr"}, 16'(jmp_addr), 16'hF);
    check({tag, "_alu_en"},   16'(alu_en),   16'h0);
    check({tag, "_alu_func"}, 16'(alu_func), 16'h0);
    check({tag, "_jmp"},      16'(jmp),      16'h0);
    check({tag, "_jmp_nz"},   16'(jmp_nz),   16'h0);
    check({tag, "_dont_jmp"}, 16'(dont_jmp), 16'h0);
    check({tag, "_count"},    instr_count,   16'h0);
  endtask

  initial begin
    vec_t e;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    pm_data  = 8'hD0;
    alu_zero = 1'b0;

    //          word   az  v  reg_en src ui imm ae af j  jn dj count
    vecs.push_back(mk(8'h35, 0, 1, 8'h08, 3'd5, 1, 4'h5, 0, 3'd5, 0, 0, 0, 16'd0));
    vecs.push_back(mk(8'h8B, 0, 1, 8'h02, 3'd3, 0, 4'hB, 0, 3'd3, 0, 0, 0, 16'd1));
    vecs.push_back(mk(8'h92, 0, 1, 8'h00, 3'd2, 0, 4'h2, 0, 3'd2, 0, 0, 0, 16'd2));
    vecs.push_back(mk(8'hBF, 0, 1, 8'h00, 3'd7, 0, 4'hF, 0, 3'd7, 0, 0, 0, 16'd3));
    vecs.push_back(mk(8'hE7, 0, 1, 8'h00, 3'd7, 0, 4'h7, 0, 3'd7, 1, 0, 0, 16'd4));
    vecs.push_back(mk(8'h11, 0, 0, 8'h00, 3'd1, 0, 4'h1, 0, 3'd0, 0, 0, 0, 16'd5));
    vecs.push_back(mk(8'hC3, 1, 1, 8'h00, 3'd3, 0, 4'h3, 1, 3'd3, 0, 0, 0, 16'd5));
    vecs.push_back(mk(8'hF4, 0, 1, 8'h00, 3'd4, 0, 4'h4, 0, 3'd4, 0, 1, 1, 16'd6));
    vecs.push_back(mk(8'h20, 0, 1, 8'h04, 3'd0, 1, 4'h0, 0, 3'd0, 0, 0, 1, 16'd7));
    vecs.push_back(mk(8'hC3, 0, 1, 8'h00, 3'd3, 0, 4'h3, 1, 3'd3, 0, 0, 1, 16'd8));
    vecs.push_back(mk(8'hF4, 0, 1, 8'h00, 3'd4, 0, 4'h4, 0, 3'd4, 0, 1, 0, 16'd9));
    vecs.push_back(mk(8'h66, 0, 0, 8'h00, 3'd6, 0, 4'h6, 0, 3'd0, 0, 0, 0, 16'd10));
    vecs.push_back(mk(8'hC8, 1, 1, 8'h00, 3'd0, 0, 4'h8, 0, 3'd0, 0, 0, 0, 16'd10));
    vecs.push_back(mk(8'hD5, 1, 1, 8'h00, 3'd5, 0, 4'h5, 0, 3'd5, 0, 0, 0, 16'd11));
    vecs.push_back(mk(8'h9C, 0, 1, 8'h08, 3'd4, 0, 4'hC, 0, 3'd4, 0, 0, 0, 16'd12));

    // Reset held while the clock runs with words on pm_data.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      pm_data = vecs[i].word;
      sb.push_back(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      compare(e, i);
      alu_zero = e.az;
    end
    alu_zero = 1'b0;

    // Reset asserted while a taken jump sits in ir: the pending squash
    // must be dropped, so the first word after release is live.
    pm_data = 8'hE2;
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_jmp", 16'(jmp), 16'h1);
    reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    pm_data = 8'h8B;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_valid",  16'(ir_valid), 16'h1);
    check("post_reset_reg_en", 16'(reg_en),   16'h02);
    check("post_reset_count",  instr_count,   16'h0);

    // Counter wrap: a stream of NOPs keeps ir_valid high every cycle.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    pm_data = 8'hD0;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    check("count_ffff", instr_count, 16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    check("count_wrap", instr_count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Decode stage of the CME341 microprocessor, directly downstream of program memory and feeding the program sequencer. It registers each 8-bit instruction word fetched at `pm_addr` into an instruction register and decodes it into register-load enables, source selects, an immediate nibble and ALU function controls. It drives the sequencer's `jmp`, `jmp_nz`, `jmp_addr` and `dont_jmp` inputs, and holds the zero flag. After a taken jump it squashes the one fall-through fetch.

## Interface
- `NOP_WORD`, default 8'hDF — instruction register value at reset; decodes to no operation.
- `clk` in 1 — system clock, all state updates on rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `pm_data` in 8 — instruction word from program memory, valid each cycle.
- `alu_zero` in 1 — combinational "ALU result == 0" from ALU for the instruction currently in `ir`.
- `ir` out 8 — instruction register.
- `ir_valid` out 1 — `ir` holds a live instruction (0 = bubble).
- `reg_en` out 8 — one-hot load enable: [0]x0 [1]x1 [2]y0 [3]y1 [4]o_reg [5]m [6]i; bit [7] is always 0.
- `src_sel` out 3 — data-bus source for moves: 0–6 same map as `reg_en`, 7 = r (ALU result).
- `use_imm` out 1 — data bus takes `imm` instead of `src_sel`.
- `imm` out 4 — immediate nibble, `ir[3:0]`.
- `alu_en` out 1 — ALU executes `alu_func` this cycle; r loads at the edge.
- `alu_func` out 3 — `ir[2:0]`.
- `jmp`, `jmp_nz` out 1 — to sequencer.
- `jmp_addr` out 4 — `ir[3:0]`, to sequencer.
- `dont_jmp` out 1 — equals `z_flag`, to sequencer.
- `instr_count` out 16 — retired-instruction counter.

## Operation
- Encoding of `ir`:
  - 0ddd_iiii: load immediate; `reg_en[ddd]` asserted and `use_imm` = 1.
  - 10dd_dsss: move; `reg_en[ddd]` asserted and `src_sel` = sss.
  - 1100_0fff: ALU op; `alu_en` = 1.
  - 1110_aaaa: `jmp`.
  - 1111_aaaa: `jmp_nz`.
  - All other codes (1100_1xxx, 1101_xxxx): NOP.
- No-enable cases:
  - dst = 7 in a load or move: no `reg_en` bit.
  - Move with ddd == sss: treated as NOP, no enable.
- All decode outputs are combinational from `ir`. They are forced to 0 when `ir_valid` = 0; `imm`, `jmp_addr` and `src_sel` still follow `ir` bits.
- `z_flag` register:
  - Loads `alu_zero` at the edge ending a cycle with `alu_en` = 1.
  - Otherwise holds.
- Taken jump = `ir_valid` & (`jmp` | (`jmp_nz` & !`z_flag`)).
- `ir` loads `pm_data` every edge. `ir_valid` next = !taken_jump. The word fetched while a taken jump is in `ir` is the fall-through address, so it is loaded and then marked invalid (squashed).
- `instr_count` increments by 1 on each edge where `ir_valid` = 1 (NOPs and untaken `jmp_nz` count; bubbles do not). It wraps from 16'hFFFF to 0.

## Timing
- Reset (asynchronous, immediate on `reset_n` low):
  - `ir` = `NOP_WORD`, `ir_valid` = 0, `z_flag` = 0, `instr_count` = 0.
  - All decode outputs are 0 except `imm`/`jmp_addr` = 4'hF and `src_sel` = 3'h7 (from `NOP_WORD` bits).
- Release: first rising edge with `reset_n` high loads `ir` with `ir_valid` = 1.
- Reset mid-operation: all state cleared asynchronously; any pending squash is discarded.
- Latency:
  - Word on `pm_data` at edge k appears decoded from edge k to k+1.
  - Its register write or r update occurs at edge k+1.
- Jump: `jmp`/`jmp_nz` are combinational from `ir`, so the sequencer redirects `pm_addr` in the same cycle. Exactly one bubble follows a taken jump.
- Untaken `jmp_nz` (`z_flag` = 1): no bubble; `jmp_nz` still asserted, and the sequencer uses `dont_jmp`.
- Flag hazard: ALU op followed immediately by `jmp_nz` sees the flag from that ALU op (updated at the intervening edge). No stall.
- Back-to-back taken jumps: cannot occur, because the second is always squashed.

## Test plan
- Reset: hold `reset_n` = 0 mid-stream → all outputs at reset values, `instr_count` = 0. Release, feed 8'h35 → next cycle `reg_en` = 8'h08, `use_imm` = 1, `imm` = 4'h5, `ir_valid` = 1.
- Moves: feed 8'h8B (x1←y1) → `reg_en` = 8'h02, `src_sel` = 3. Feed 8'h92 (y0←y0) → `reg_en` = 0. Feed 8'hBF (dst 7) → no enable.
- Jump squash: feed 8'hE7 then 8'h11 → `jmp` = 1, `jmp_addr` = 7, next cycle `ir_valid` = 0 and `reg_en` = 0, and `instr_count` advances by 1 only for the jump.
- Zero flag: ALU op 8'hC3 with `alu_zero` = 1, then 8'hF4 → `dont_jmp` = 1, no bubble. Repeat with `alu_zero` = 0 → `jmp_nz` taken, one bubble.
- NOP/reserved: feed 8'hC8 and 8'hD5 → all enables 0, `z_flag` unchanged, `instr_count` +1 each.
- Counter wrap: preload via 65535 valid cycles → `instr_count` = 16'hFFFF, next valid cycle reads 0.
